// File: rtl/ramp_adc_capture.sv
// rtl/ramp_adc_capture.sv - single-slope ramp ADC controller (option macro: RAMP_ADC_CONTINUOUS_EN)
module ramp_adc_capture #(
  parameter int WIDTH        = 8,
  parameter int SETTLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             sample_valid,
  output logic [WIDTH-1:0] sample_code,
  output logic             overrange
);

  localparam int HW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(SETTLE_TICKS - 1);
  localparam logic [WIDTH-1:0] CODE_MAX  = '1;

  // The comparator must have fully propagated through the synchroniser before
  // the evaluate cycle of each code, otherwise a code is judged on stale data.
  if (SETTLE_TICKS < SYNC_STAGES + 1) begin : g_bad_cfg
    $error("ramp_adc_capture: SETTLE_TICKS must be >= SYNC_STAGES+1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cmp_sync;
  logic [HW-1:0]          hold_cnt, hold_d;
  logic [WIDTH-1:0]       dac_d, code_d;
  logic                   ovr_d;
  logic                   start_go;
  logic                   evaluate;

`ifdef RAMP_ADC_CONTINUOUS_EN
  // Free-running: every IDLE/DONE exit re-arms the ramp; start is not used.
  logic unused_start;
  assign unused_start = start;
  assign start_go     = 1'b1;
`else
  assign start_go     = start;
`endif

  assign cmp_sync = sync_q[SYNC_STAGES-1];
  assign evaluate = (hold_cnt == HOLD_LAST);

  // Synchronise the asynchronous comparator output into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= cmp_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // State, ramp code, settle counter and held result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dac_code    <= '0;
      hold_cnt    <= '0;
      sample_code <= '0;
      overrange   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_code    <= dac_d;
      hold_cnt    <= hold_d;
      sample_code <= code_d;
      overrange   <= ovr_d;
    end
  end

  // Next-state and output decode; the result is captured on the evaluate edge
  // so it is already valid during the single DONE cycle.
  always_comb begin
    state_d      = state_q;
    dac_d        = dac_code;
    hold_d       = hold_cnt;
    code_d       = sample_code;
    ovr_d        = overrange;
    busy         = 1'b0;
    sample_valid = 1'b0;
    case (state_q)
      IDLE: begin
        dac_d  = '0;
        hold_d = '0;
        if (start_go) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        busy = 1'b1;
        if (!evaluate) begin
          hold_d = hold_cnt + HW'(1);
        end else if (cmp_sync) begin
          code_d  = dac_code;
          ovr_d   = 1'b0;
          dac_d   = '0;
          hold_d  = '0;
          state_d = DONE;
        end else if (dac_code == CODE_MAX) begin
          code_d  = CODE_MAX;
          ovr_d   = 1'b1;
          dac_d   = '0;
          hold_d  = '0;
          state_d = DONE;
        end else begin
          dac_d  = dac_code + WIDTH'(1);
          hold_d = '0;
        end
      end
      DONE: begin
        sample_valid = 1'b1;
        dac_d        = '0;
        hold_d       = '0;
`ifdef RAMP_ADC_CONTINUOUS_EN
        state_d      = RAMP;
`else
        state_d      = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        dac_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

endmodule
